// File: rtl/ahb_sram_arbiter.sv
// Two-master AHB arbiter/mux for the SRAM port: registered one-hot grant, address-phase and data-phase owner pipeline.
// Grant changes only at burst ends or on an error; all state stalls while hready_resp is low.
module ahb_sram_arbiter #(
    parameter logic [31:0] SRAM_BASE = 32'h0000_0000,
    parameter logic [31:0] SRAM_SIZE = 32'h0001_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        m0_hbusreq,
    input  logic        m1_hbusreq,
    input  logic [31:0] m0_haddr,
    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic [1:0]  m1_htrans,
    input  logic        m0_hwrite,
    input  logic        m1_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [2:0]  m1_hsize,
    input  logic [2:0]  m0_hburst,
    input  logic [2:0]  m1_hburst,
    input  logic [31:0] m0_hwdata,
    input  logic [31:0] m1_hwdata,
    output logic [1:0]  hgrant,
    output logic        hmaster,
    output logic        hsel,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    output logic        hready,
    input  logic        hready_resp,
    input  logic [1:0]  hresp
);
    localparam logic [31:0] WIN_MASK = ~(SRAM_SIZE - 32'd1);
    localparam logic [1:0]  T_IDLE   = 2'b00;
    localparam logic [1:0]  T_BUSY   = 2'b01;
    localparam logic [1:0]  T_NONSEQ = 2'b10;
    localparam logic [1:0]  T_SEQ    = 2'b11;
    localparam logic [1:0]  R_ERROR  = 2'b01;

    logic [1:0] hgrant_q, hgrant_d;
    logic       hmaster_q;
    logic       hmaster_dp_q;
    logic [3:0] beats_q, beats_d;
    logic       err_q;
    logic       win_open;
    logic [1:0] gnt_sel;

    assign hready  = hready_resp;
    assign hgrant  = hgrant_q;
    assign hmaster = hmaster_q;

    assign haddr  = hmaster_q ? m1_haddr  : m0_haddr;
    assign htrans = hmaster_q ? m1_htrans : m0_htrans;
    assign hwrite = hmaster_q ? m1_hwrite : m0_hwrite;
    assign hsize  = hmaster_q ? m1_hsize  : m0_hsize;
    assign hburst = hmaster_q ? m1_hburst : m0_hburst;
    assign hwdata = hmaster_dp_q ? m1_hwdata : m0_hwdata;

    assign hsel = htrans[1] && ((haddr & WIN_MASK) == SRAM_BASE);

    // Remaining beats of a fixed-length burst after this address phase is accepted.
    always_comb begin
        beats_d = beats_q;
        case (htrans)
            T_IDLE:   beats_d = 4'd0;
            T_BUSY:   beats_d = beats_q;
            T_NONSEQ: begin
                case (hburst[2:1])
                    2'b01:   beats_d = 4'd3;
                    2'b10:   beats_d = 4'd7;
                    2'b11:   beats_d = 4'd15;
                    default: beats_d = 4'd0;
                endcase
            end
            T_SEQ:    beats_d = (beats_q == 4'd0) ? 4'd0 : beats_q - 4'd1;
            default:  beats_d = beats_q;
        endcase
    end

    assign win_open = hready_resp && (err_q || (beats_d <= 4'd1) || (htrans == T_IDLE));

    // Round-robin between two requesters; park on the last grant when nobody asks.
    always_comb begin
        gnt_sel = hgrant_q;
        case ({m1_hbusreq, m0_hbusreq})
            2'b01:   gnt_sel = 2'b01;
            2'b10:   gnt_sel = 2'b10;
            2'b11:   gnt_sel = hgrant_q[0] ? 2'b10 : 2'b01;
            default: gnt_sel = hgrant_q;
        endcase
        hgrant_d = win_open ? gnt_sel : hgrant_q;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hgrant_q     <= 2'b01;
            hmaster_q    <= 1'b0;
            hmaster_dp_q <= 1'b0;
            beats_q      <= 4'd0;
            err_q        <= 1'b0;
        end else if (hready_resp) begin
            hgrant_q     <= hgrant_d;
            hmaster_q    <= hgrant_q[1];
            hmaster_dp_q <= hmaster_q;
            beats_q      <= beats_d;
            err_q        <= 1'b0;
        end else if (hresp == R_ERROR) begin
            // First error cycle: abandon the burst so the next ready edge can rearbitrate.
            beats_q <= 4'd0;
            err_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Bench for ahb_sram_arbiter: vector table for single transfers, hand sequences for bursts, waits, errors and reset.
module tb_ahb_sram_arbiter;
    logic        hclk = 1'b0;
    logic        hresetn = 1'b1;
    logic        m0_hbusreq, m1_hbusreq;
    logic [31:0] m0_haddr, m1_haddr;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic [2:0]  m0_hburst, m1_hburst;
    logic [31:0] m0_hwdata, m1_hwdata;
    logic [1:0]  hgrant;
    logic        hmaster, hsel, hwrite, hready;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic        hready_resp;
    logic [1:0]  hresp;

    ahb_sram_arbiter dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_hbusreq(m0_hbusreq), .m1_hbusreq(m1_hbusreq),
        .m0_haddr(m0_haddr), .m1_haddr(m1_haddr),
        .m0_htrans(m0_htrans), .m1_htrans(m1_htrans),
        .m0_hwrite(m0_hwrite), .m1_hwrite(m1_hwrite),
        .m0_hsize(m0_hsize), .m1_hsize(m1_hsize),
        .m0_hburst(m0_hburst), .m1_hburst(m1_hburst),
        .m0_hwdata(m0_hwdata), .m1_hwdata(m1_hwdata),
        .hgrant(hgrant), .hmaster(hmaster), .hsel(hsel),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready(hready), .hready_resp(hready_resp), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        r0, r1;
        logic [1:0]  t0;
        logic [31:0] a0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        rdy;
        logic [1:0]  e_gnt;
        logic        e_hm;
        logic        e_sel;
    } vec_t;

    vec_t tbl[19];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   sbq[$];

    function automatic vec_t mk(input logic r0, input logic r1, input logic [1:0] t0,
                                input logic [31:0] a0, input logic [1:0] t1, input logic [31:0] a1,
                                input logic rdy, input logic [1:0] e_gnt, input logic e_hm,
                                input logic e_sel);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1;
        v.rdy = rdy; v.e_gnt = e_gnt; v.e_hm = e_hm; v.e_sel = e_sel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic [1:0] t0, input logic [2:0] b0,
                         input logic [31:0] a0, input logic [1:0] t1, input logic [2:0] b1,
                         input logic [31:0] a1, input logic rdy, input logic [1:0] resp);
        m0_hbusreq = r0; m1_hbusreq = r1;
        m0_htrans = t0; m0_hburst = b0; m0_haddr = a0;
        m1_htrans = t1; m1_hburst = b1; m1_haddr = a1;
        hready_resp = rdy; hresp = resp;
    endtask

    task automatic next_cycle();
        @(posedge hclk);
        #1;
        cyc++;
        m0_hwdata = 32'hA000_0000 + cyc;
        m1_hwdata = 32'hB000_0000 + cyc;
    endtask

    // Checks grant/owner and the data-phase scoreboard, then queues the expected owner of the next data phase.
    task automatic eval(input string tag, input logic [1:0] e_gnt, input logic e_hm);
        logic [1:0] own_trans;
        #4;
        chk({tag, ".hgrant"}, {30'd0, hgrant}, {30'd0, e_gnt});
        chk({tag, ".hmaster"}, {31'd0, hmaster}, {31'd0, e_hm});
        chk({tag, ".hready"}, {31'd0, hready}, {31'd0, hready_resp});
        if (sbq.size() > 0) begin
            chk({tag, ".hwdata"}, hwdata, sbq[0] ? 32'hB000_0000 + cyc : 32'hA000_0000 + cyc);
            if (hready_resp) void'(sbq.pop_front());
        end
        own_trans = e_hm ? m1_htrans : m0_htrans;
        if (hready_resp && own_trans[1]) sbq.push_back(e_hm);
    endtask

    task automatic chk_addr(input string tag, input logic e_hm, input logic e_sel);
        chk({tag, ".haddr"}, haddr, e_hm ? m1_haddr : m0_haddr);
        chk({tag, ".htrans"}, {30'd0, htrans}, {30'd0, e_hm ? m1_htrans : m0_htrans});
        chk({tag, ".hburst"}, {29'd0, hburst}, {29'd0, e_hm ? m1_hburst : m0_hburst});
        chk({tag, ".hsize"}, {29'd0, hsize}, e_hm ? 32'd1 : 32'd2);
        chk({tag, ".hwrite"}, {31'd0, hwrite}, {31'd0, e_hm});
        chk({tag, ".hsel"}, {31'd0, hsel}, {31'd0, e_sel});
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h20, 1'b1, 2'd0);
        hresetn = 1'b0;
        #1;
        chk({tag, ".hgrant"}, {30'd0, hgrant}, 32'd1);
        chk({tag, ".hmaster"}, {31'd0, hmaster}, 32'd0);
        chk({tag, ".hsel"}, {31'd0, hsel}, 32'd0);
        @(posedge hclk);
        #3;
        hresetn = 1'b1;
        sbq.delete();
    endtask

    initial begin
        m0_hwrite = 1'b0; m1_hwrite = 1'b1;
        m0_hsize = 3'd2;  m1_hsize = 3'd1;
        m0_hwdata = '0;   m1_hwdata = '0;
        drive(1'b0, 1'b0, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h20, 1'b1, 2'd0);

        tbl[0]  = mk(0, 0, 2'd0, 32'h10,  2'd0, 32'h20,    1, 2'b01, 0, 0);
        tbl[1]  = mk(0, 0, 2'd0, 32'h10,  2'd0, 32'h20,    0, 2'b01, 0, 0);
        tbl[2]  = mk(0, 1, 2'd0, 32'h10,  2'd0, 32'h40,    1, 2'b01, 0, 0);
        tbl[3]  = mk(0, 1, 2'd0, 32'h10,  2'd0, 32'h40,    1, 2'b10, 0, 0);
        tbl[4]  = mk(0, 1, 2'd2, 32'h44,  2'd2, 32'h40,    1, 2'b10, 1, 1);
        tbl[5]  = mk(0, 0, 2'd0, 32'h10,  2'd0, 32'h40,    1, 2'b10, 1, 0);
        tbl[6]  = mk(1, 1, 2'd2, 32'h100, 2'd2, 32'h80,    1, 2'b10, 1, 1);
        tbl[7]  = mk(1, 1, 2'd2, 32'h104, 2'd2, 32'h84,    1, 2'b01, 1, 1);
        tbl[8]  = mk(1, 1, 2'd2, 32'h108, 2'd2, 32'h88,    1, 2'b10, 0, 1);
        tbl[9]  = mk(1, 1, 2'd2, 32'h10C, 2'd2, 32'h8C,    1, 2'b01, 1, 1);
        tbl[10] = mk(1, 1, 2'd2, 32'h110, 2'd2, 32'h90,    1, 2'b10, 0, 1);
        tbl[11] = mk(0, 0, 2'd0, 32'h10,  2'd0, 32'h94,    1, 2'b01, 1, 0);
        tbl[12] = mk(0, 1, 2'd0, 32'h10,  2'd0, 32'h94,    1, 2'b01, 0, 0);
        tbl[13] = mk(0, 1, 2'd0, 32'h10,  2'd0, 32'h94,    1, 2'b10, 0, 0);
        tbl[14] = mk(0, 1, 2'd2, 32'h100, 2'd2, 32'h2_0000, 1, 2'b10, 1, 0);
        tbl[15] = mk(0, 0, 2'd2, 32'h100, 2'd2, 32'hFFFC,  1, 2'b10, 1, 1);
        tbl[16] = mk(0, 0, 2'd2, 32'h100, 2'd1, 32'h10,    1, 2'b10, 1, 0);
        tbl[17] = mk(0, 0, 2'd2, 32'h100, 2'd2, 32'h1_0000, 1, 2'b10, 1, 0);
        tbl[18] = mk(0, 0, 2'd0, 32'h10,  2'd0, 32'h0,     1, 2'b10, 1, 0);

        #2;
        do_reset("rst0");

        foreach (tbl[i]) begin
            next_cycle();
            drive(tbl[i].r0, tbl[i].r1, tbl[i].t0, 3'd0, tbl[i].a0,
                  tbl[i].t1, 3'd0, tbl[i].a1, tbl[i].rdy, 2'd0);
            eval($sformatf("v%0d", i), tbl[i].e_gnt, tbl[i].e_hm);
            chk_addr($sformatf("v%0d", i), tbl[i].e_hm, tbl[i].e_sel);
        end

        // m1 owns the bus here; reset must take effect without a clock edge.
        do_reset("rst_async");

        // INCR4 from m0 with m1 waiting: handover after the third beat edge.
        next_cycle();
        drive(1, 0, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h0, 1, 2'd0);
        eval("t3.pre", 2'b01, 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(0, 1, (i == 0) ? 2'd2 : 2'd3, 3'd3, 32'h200 + 32'(4 * i),
                  2'd0, 3'd0, 32'h0, 1, 2'd0);
            eval($sformatf("t3.b%0d", i), (i == 3) ? 2'b10 : 2'b01, 0);
            chk_addr($sformatf("t3.b%0d", i), 0, 1);
        end
        next_cycle();
        drive(0, 1, 2'd0, 3'd0, 32'h10, 2'd2, 3'd0, 32'h300, 1, 2'd0);
        eval("t3.m1", 2'b10, 1);
        chk_addr("t3.m1", 1, 1);
        next_cycle();
        drive(0, 0, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h0, 1, 2'd0);
        eval("t3.end", 2'b10, 1);

        // INCR8 from m0 with three wait states on the fifth beat.
        do_reset("rst_t5");
        next_cycle();
        drive(1, 0, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h0, 1, 2'd0);
        eval("t5.pre", 2'b01, 0);
        for (int c = 0; c < 11; c++) begin
            int beat;
            beat = (c < 4) ? c : ((c < 7) ? 4 : c - 3);
            next_cycle();
            drive(0, 1, (beat == 0) ? 2'd2 : 2'd3, 3'd5, 32'h400 + 32'(4 * beat),
                  2'd0, 3'd0, 32'h0, !(c >= 4 && c < 7), 2'd0);
            eval($sformatf("t5.c%0d", c), (c >= 10) ? 2'b10 : 2'b01, 0);
            chk_addr($sformatf("t5.c%0d", c), 0, 1);
        end
        next_cycle();
        drive(0, 1, 2'd0, 3'd0, 32'h10, 2'd2, 3'd0, 32'h500, 1, 2'd0);
        eval("t5.m1", 2'b10, 1);
        chk_addr("t5.m1", 1, 1);
        next_cycle();
        drive(0, 0, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h0, 1, 2'd0);
        eval("t5.end", 2'b10, 1);

        // ERROR in the middle of an INCR16 from m1 with m0 requesting.
        do_reset("rst_err");
        next_cycle();
        drive(0, 1, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h0, 1, 2'd0);
        eval("er.req", 2'b01, 0);
        next_cycle();
        drive(0, 1, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h0, 1, 2'd0);
        eval("er.gnt", 2'b10, 0);
        next_cycle();
        drive(1, 1, 2'd0, 3'd0, 32'h10, 2'd2, 3'd7, 32'h600, 1, 2'd0);
        eval("er.b0", 2'b10, 1);
        chk_addr("er.b0", 1, 1);
        next_cycle();
        drive(1, 1, 2'd0, 3'd0, 32'h10, 2'd3, 3'd7, 32'h604, 1, 2'd0);
        eval("er.b1", 2'b10, 1);
        next_cycle();
        drive(1, 1, 2'd0, 3'd0, 32'h10, 2'd3, 3'd7, 32'h608, 0, 2'd1);
        eval("er.e1", 2'b10, 1);
        next_cycle();
        drive(1, 1, 2'd0, 3'd0, 32'h10, 2'd3, 3'd7, 32'h608, 1, 2'd1);
        eval("er.e2", 2'b10, 1);
        next_cycle();
        drive(1, 1, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h0, 1, 2'd0);
        eval("er.hand", 2'b01, 1);
        next_cycle();
        drive(0, 0, 2'd0, 3'd0, 32'h10, 2'd0, 3'd0, 32'h0, 1, 2'd0);
        eval("er.end", 2'b10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
